// File: rtl/adc_frame_aligner.sv
// adc_frame_aligner
//   Reassembles LANES samples of BITS bits from per-lane DDR bit pairs and
//   finds the frame bit offset by hunting on the sampled FCO pattern.
//   All logic runs on the rising edge of dco_clk. Reset is asynchronous and
//   active-high.
//
// Ports
//   dco_clk      capture clock
//   rst          asynchronous active-high reset
//   bit_rise     per-lane bit captured on the rising edge (earlier bit)
//   bit_fall     per-lane bit captured on the falling edge (later bit)
//   fco_rise     FCO sampled on the rising edge
//   fco_fall     FCO sampled on the falling edge
//   stall        downstream full; frames completing while high are dropped
//   force_hunt   single-cycle pulse restarting alignment (slip kept)
//   sample_data  aligned samples, lane i at [i*BITS +: BITS], MSB first bit
//   sample_valid one-cycle pulse per emitted frame
//   frame_err    qualifies sample_valid: emitted while locked, FCO mismatched
//   aligned      high while in the LOCKED state
//   slip         current bit offset of the frame window
//   err_count    saturating count of locked-state FCO mismatches
//   drop_count   saturating count of frames dropped because of stall
//
// Build option
//   ADC_FRAME_ALIGNER_STATS_EN  when defined, err_count/drop_count count;
//                               otherwise both are tied to zero and the
//                               counter registers do not exist.

module adc_frame_aligner #(
  parameter int LANES      = 8,
  parameter int BITS       = 16,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                     dco_clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         bit_rise,
  input  logic [LANES-1:0]         bit_fall,
  input  logic                     fco_rise,
  input  logic                     fco_fall,
  input  logic                     stall,
  input  logic                     force_hunt,
  output logic [LANES*BITS-1:0]    sample_data,
  output logic                     sample_valid,
  output logic                     frame_err,
  output logic                     aligned,
  output logic [$clog2(BITS)-1:0]  slip,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int HIST_W = 2 * BITS;
  localparam int SLIP_W = $clog2(BITS);
  localparam int CYC_W  = $clog2(BITS / 2);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  localparam logic [CYC_W-1:0]  CYC_LAST    = CYC_W'(BITS / 2 - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST   = SLIP_W'(BITS - 1);
  localparam logic [BITS-1:0]   FCO_PATTERN = {{(BITS/2){1'b1}}, {(BITS/2){1'b0}}};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SLIP_W-1:0]       slip_q, slip_d;
  logic [GOOD_W-1:0]       good_q, good_d;
  logic [MISS_W-1:0]       miss_q, miss_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic [HIST_W-1:0]       fco_hist_q, fco_hist_d;
  logic [HIST_W-1:0]       lane_hist_q [LANES];
  logic [HIST_W-1:0]       lane_hist_d [LANES];
  logic [LANES*BITS-1:0]   sample_data_q, sample_data_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    aligned_q, aligned_d;

  logic                    boundary_s;
  logic [BITS-1:0]         fco_window_s;
  logic                    fco_match_s;
  logic [LANES*BITS-1:0]   lane_window_s;
  logic [SLIP_W-1:0]       slip_next_s;
  logic                    err_inc_s;
  logic                    drop_inc_s;
  logic                    unused_hist_s;

  // Shift two bits per cycle into every history (rise is older) and step the frame counter.
  always_comb begin
    fco_hist_d = {fco_hist_q[HIST_W-3:0], fco_rise, fco_fall};
    for (int i = 0; i < LANES; i++) begin
      lane_hist_d[i] = {lane_hist_q[i][HIST_W-3:0], bit_rise[i], bit_fall[i]};
    end
    boundary_s = (cyc_q == CYC_LAST);
    if (boundary_s) begin
      cyc_d = {CYC_W{1'b0}};
    end else begin
      cyc_d = cyc_q + CYC_W'(1);
    end
  end

  // Extract the BITS-wide windows at offset slip from the newest bit, including this cycle's pair.
  always_comb begin
    fco_window_s = fco_hist_d[slip_q +: BITS];
    fco_match_s  = (fco_window_s == FCO_PATTERN);
    lane_window_s = {(LANES*BITS){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      lane_window_s[i*BITS +: BITS] = lane_hist_d[i][slip_q +: BITS];
    end
    if (slip_q == SLIP_LAST) begin
      slip_next_s = {SLIP_W{1'b0}};
    end else begin
      slip_next_s = slip_q + SLIP_W'(1);
    end
  end

  // The two oldest history bits only exist to give the full depth; nothing reads them.
  always_comb begin
    unused_hist_s = fco_hist_q[HIST_W-1] ^ fco_hist_q[HIST_W-2];
    for (int i = 0; i < LANES; i++) begin
      unused_hist_s = unused_hist_s ^ lane_hist_q[i][HIST_W-1] ^ lane_hist_q[i][HIST_W-2];
    end
  end

  // Alignment FSM: decisions only at frame boundaries, force_hunt overrides the decision.
  always_comb begin
    state_d   = state_q;
    slip_d    = slip_q;
    good_d    = good_q;
    miss_d    = miss_q;
    err_inc_s = 1'b0;
    if (boundary_s) begin
      case (state_q)
        ST_HUNT: begin
          if (fco_match_s) begin
            if (LOCK_COUNT == 1) begin
              state_d = ST_LOCKED;
              miss_d  = {MISS_W{1'b0}};
            end else begin
              state_d = ST_VERIFY;
              good_d  = GOOD_W'(1);
            end
          end else begin
            slip_d = slip_next_s;
          end
        end
        ST_VERIFY: begin
          if (fco_match_s) begin
            good_d = good_q + GOOD_W'(1);
            if ((int'(good_q) + 1) >= LOCK_COUNT) begin
              state_d = ST_LOCKED;
              miss_d  = {MISS_W{1'b0}};
            end else begin
              state_d = ST_VERIFY;
            end
          end else begin
            state_d = ST_HUNT;
            good_d  = {GOOD_W{1'b0}};
            slip_d  = slip_next_s;
          end
        end
        ST_LOCKED: begin
          if (fco_match_s) begin
            miss_d = {MISS_W{1'b0}};
          end else begin
            err_inc_s = 1'b1;
            if ((int'(miss_q) + 1) >= LOSS_COUNT) begin
              // Lock lost: hunting resumes from the current offset.
              state_d = ST_HUNT;
              miss_d  = {MISS_W{1'b0}};
              good_d  = {GOOD_W{1'b0}};
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          good_d  = {GOOD_W{1'b0}};
          miss_d  = {MISS_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (force_hunt) begin
      state_d = ST_HUNT;
      good_d  = {GOOD_W{1'b0}};
      miss_d  = {MISS_W{1'b0}};
      slip_d  = slip_q;
    end else begin
      slip_d = slip_d;
    end
  end

  // Frame emission from the pre-update state; a stalled locked boundary is dropped instead.
  always_comb begin
    sample_data_d  = sample_data_q;
    frame_err_d    = frame_err_q;
    sample_valid_d = 1'b0;
    drop_inc_s     = 1'b0;
    if (boundary_s && (state_q == ST_LOCKED)) begin
      if (stall) begin
        drop_inc_s = 1'b1;
      end else begin
        sample_data_d  = lane_window_s;
        frame_err_d    = ~fco_match_s;
        sample_valid_d = 1'b1;
      end
    end else begin
      sample_valid_d = 1'b0;
    end
    aligned_d = (state_d == ST_LOCKED);
  end

  // State, history and output registers.
  always_ff @(posedge dco_clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_HUNT;
      slip_q         <= {SLIP_W{1'b0}};
      good_q         <= {GOOD_W{1'b0}};
      miss_q         <= {MISS_W{1'b0}};
      cyc_q          <= {CYC_W{1'b0}};
      fco_hist_q     <= {HIST_W{1'b0}};
      for (int i = 0; i < LANES; i++) begin
        lane_hist_q[i] <= {HIST_W{1'b0}};
      end
      sample_data_q  <= {(LANES*BITS){1'b0}};
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      aligned_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      slip_q         <= slip_d;
      good_q         <= good_d;
      miss_q         <= miss_d;
      cyc_q          <= cyc_d;
      fco_hist_q     <= fco_hist_d;
      for (int i = 0; i < LANES; i++) begin
        lane_hist_q[i] <= lane_hist_d[i];
      end
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      frame_err_q    <= frame_err_d;
      aligned_q      <= aligned_d;
    end
  end

  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;
  assign aligned      = aligned_q;
  assign slip         = slip_q;

`ifdef ADC_FRAME_ALIGNER_STATS_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  // Saturating statistics counters.
  always_comb begin
    err_count_d  = err_count_q;
    drop_count_d = drop_count_q;
    if (err_inc_s && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
    if (drop_inc_s && (drop_count_q != {CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Counter registers, cleared only by rst.
  always_ff @(posedge dco_clk or posedge rst) begin
    if (rst) begin
      err_count_q  <= {CNT_W{1'b0}};
      drop_count_q <= {CNT_W{1'b0}};
    end else begin
      err_count_q  <= err_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign err_count  = err_count_q;
  assign drop_count = drop_count_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = err_inc_s ^ drop_inc_s;
  assign err_count      = {CNT_W{1'b0}};
  assign drop_count     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Testbench for adc_frame_aligner (LANES=8, BITS=16, LOCK_COUNT=4,
// LOSS_COUNT=3). A bit-stream generator produces FCO and lane data at a
// chosen bit offset; expected frames go into a scoreboard queue at the
// boundary cycle that should emit them and are popped on sample_valid.
module tb_adc_frame_aligner;

  localparam int LANES      = 8;
  localparam int BITS       = 16;
  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 3;
  localparam int CNT_W      = 16;
  localparam int DW         = LANES * BITS;
  localparam int HALF       = BITS / 2;
`ifdef ADC_FRAME_ALIGNER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              dco_clk = 1'b0;
  logic              rst = 1'b1;
  logic [LANES-1:0]  bit_rise = '0;
  logic [LANES-1:0]  bit_fall = '0;
  logic              fco_rise = 1'b0;
  logic              fco_fall = 1'b0;
  logic              stall = 1'b0;
  logic              force_hunt = 1'b0;
  logic [DW-1:0]     sample_data;
  logic              sample_valid;
  logic              frame_err;
  logic              aligned;
  logic [3:0]        slip;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  drop_count;

  adc_frame_aligner #(
    .LANES(LANES), .BITS(BITS), .LOCK_COUNT(LOCK_COUNT),
    .LOSS_COUNT(LOSS_COUNT), .CNT_W(CNT_W)
  ) dut (
    .dco_clk(dco_clk), .rst(rst), .bit_rise(bit_rise), .bit_fall(bit_fall),
    .fco_rise(fco_rise), .fco_fall(fco_fall), .stall(stall),
    .force_hunt(force_hunt), .sample_data(sample_data),
    .sample_valid(sample_valid), .frame_err(frame_err), .aligned(aligned),
    .slip(slip), .err_count(err_count), .drop_count(drop_count)
  );

  always #5 dco_clk = ~dco_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  // One phase of stimulus: nframes frames with the given conditions, then
  // the expected status at the end of the phase.
  typedef struct {
    int nframes;
    bit corrupt;
    bit stl;
    bit emit;
    bit err;
    bit aligned;
    int slip;
    int errc;
    int dropc;
  } row_t;

  exp_t sb_q[$];
  row_t rows [0:20];
  int   checks = 0;
  int   failures = 0;
  int   tcyc = 0;
  int   offs = 0;
  bit   const_data = 1'b1;

  function automatic logic [BITS-1:0] sample_of(int f, int lane);
    if (const_data) return 16'hA500 + 16'(lane);
    else return {4'hA, 8'(f), 4'(lane)};
  endfunction

  function automatic logic data_bit(int n, int lane);
    int p;
    logic [BITS-1:0] s;
    p = n + offs;
    s = sample_of(p / BITS, lane);
    return s[BITS-1 - (p % BITS)];
  endfunction

  // FCO: HALF ones then HALF zeros; corruption flips the last bit of a frame.
  function automatic logic fco_bit(int n, bit corrupt);
    int pos;
    logic b;
    pos = (n + offs) % BITS;
    b = (pos < HALF);
    if (corrupt && pos == BITS - 1) b = 1'b1;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input bit st, input bit fh, input bit corrupt, input bit emit, input bit err);
    exp_t e;
    for (int i = 0; i < LANES; i++) begin
      bit_rise[i] = data_bit(2 * tcyc, i);
      bit_fall[i] = data_bit(2 * tcyc + 1, i);
    end
    fco_rise   = fco_bit(2 * tcyc, corrupt);
    fco_fall   = fco_bit(2 * tcyc + 1, corrupt);
    stall      = st;
    force_hunt = fh;
    if ((tcyc % HALF) == HALF - 1 && emit) begin
      for (int i = 0; i < LANES; i++) e.data[i*BITS +: BITS] = sample_of(tcyc / HALF, i);
      e.err = err;
      sb_q.push_back(e);
    end
    @(posedge dco_clk);
    #1;
    tcyc++;
    if (sample_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: got sample_valid=1 at cycle %0d expected 0", tcyc);
      end else begin
        e = sb_q.pop_front();
        if (sample_data !== e.data || frame_err !== e.err) begin
          failures++;
          $display("FAIL frame_out: got data=%h err=%b expected data=%h err=%b",
                   sample_data, frame_err, e.data, e.err);
        end
      end
    end
  endtask

  task automatic run_row(input int r);
    for (int f = 0; f < rows[r].nframes; f++) begin
      for (int c = 0; c < HALF; c++) begin
        tick(rows[r].stl, 1'b0, rows[r].corrupt, rows[r].emit, rows[r].err);
      end
    end
    chk($sformatf("row%0d_aligned", r), 64'(aligned), 64'(rows[r].aligned));
    chk($sformatf("row%0d_slip", r), 64'(slip), 64'(rows[r].slip));
    chk($sformatf("row%0d_err_count", r), 64'(err_count), STATS ? 64'(rows[r].errc) : 64'd0);
    chk($sformatf("row%0d_drop_count", r), 64'(drop_count), STATS ? 64'(rows[r].dropc) : 64'd0);
    chk($sformatf("row%0d_pending_frames", r), 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sample_data"}, 64'(sample_data != '0), 64'd0);
    chk({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    chk({tag, "_aligned"}, 64'(aligned), 64'd0);
    chk({tag, "_slip"}, 64'(slip), 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    force_hunt = 1'b0;
    bit_rise = '0;
    bit_fall = '0;
    fco_rise = 1'b0;
    fco_fall = 1'b0;
    repeat (2) @(posedge dco_clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tcyc = 0;
    sb_q.delete();
  endtask

  initial begin
    // nframes corrupt stall emit err | aligned slip errc dropc
    // Offset 0, constant data 16'hA500+lane.
    rows[0]  = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    rows[1]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0};
    rows[2]  = '{4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0};
    rows[3]  = '{1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1, 0};
    rows[4]  = '{2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 0};
    rows[5]  = '{3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4, 0};
    rows[6]  = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 0};
    rows[7]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4, 0};
    rows[8]  = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 4, 3};
    rows[9]  = '{2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4, 3};
    // Offset 5, per-frame data: hunting steps slip 1..5, then verify and lock.
    rows[10] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    rows[11] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 0};
    rows[12] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 0};
    rows[13] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0, 0};
    rows[14] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 0};
    rows[15] = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 0};
    rows[16] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 0, 0};
    rows[17] = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 0, 0};
    // After force_hunt: frames 2..4 of the relock, then emission again.
    rows[18] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 0};
    rows[19] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 0, 0};
    rows[20] = '{2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 0, 0};

    offs = 0;
    const_data = 1'b1;
    do_reset();
    for (int r = 0; r <= 9; r++) run_row(r);

    offs = 5;
    const_data = 1'b0;
    do_reset();
    for (int r = 10; r <= 17; r++) run_row(r);

    // force_hunt mid-frame while locked: aligned drops on the next cycle.
    for (int c = 0; c < HALF; c++) begin
      tick(1'b0, c == 2, 1'b0, 1'b0, 1'b0);
      if (c == 2) chk("force_hunt_aligned", 64'(aligned), 64'd0);
    end
    chk("force_hunt_slip_kept", 64'(slip), 64'd5);
    for (int r = 18; r <= 20; r++) run_row(r);

    // Asynchronous reset in the middle of a locked frame.
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_aligned", 64'(aligned), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge dco_clk);
    #1;
    rst = 1'b0;
    tcyc = 0;
    sb_q.delete();
    for (int r = 10; r <= 17; r++) run_row(r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
